vram_write_arbiter: RTL
=======================

// Module: vram_write_arbiter
// PURPOSE
//   Shares the single write port of the 2K x 8 video RAM between a host write channel
//   (valid/ready) and a built-in fill engine that writes one byte value over an address range.
//   Sits in front of video_ram's write_ce/write_ad/write_data. Reads are untouched.
//   Used for screen clear and region fill without stalling the host indefinitely.
// PARAMETERS
//   ADDR_W   11   video RAM address width (depth 2**ADDR_W)
//   DATA_W   8    video RAM data width
// PORTS
//   clk          in   1         single clock; also drives the video RAM write_clk
//   reset        in   1         synchronous, active-high
//   host_valid   in   1         host write request
//   host_ready   out  1         host write accepted this cycle (valid & ready = transfer)
//   host_ad      in   ADDR_W    host write address
//   host_data    in   DATA_W    host write data
//   fill_start   in   1         single-cycle pulse: begin fill (honoured only when idle)
//   fill_abort   in   1         stop an active fill; no done pulse
//   fill_base    in   ADDR_W    first fill address, sampled on accepted start
//   fill_len     in   ADDR_W+1  number of bytes (0..2**ADDR_W), sampled on accepted start
//   fill_value   in   DATA_W    fill byte, sampled on accepted start
//   fill_busy    out  1         fill in progress
//   fill_done    out  1         one-cycle pulse after last fill write issued
//   write_ce     out  1         to video_ram write_ce (registered)
//   write_ad     out  ADDR_W    to video_ram write_ad (registered)
//   write_data   out  DATA_W    to video_ram write_data (registered)
// BEHAVIOUR
//   - Reset: write_ce=0, write_ad=0, write_data=0, fill_busy=0, fill_done=0, state=IDLE,
//     turn flag=HOST. Reset mid-fill abandons the fill; no done pulse.
//   - FSM: IDLE -> FILL on fill_start & !fill_abort & fill_len!=0;
//     IDLE -> DONE on fill_start & !fill_abort & fill_len==0 (zero writes);
//     FILL -> DONE when the write with remaining count 1 is issued; FILL -> IDLE on fill_abort;
//     DONE -> IDLE unconditionally (fill_done=1 only in DONE). fill_start outside IDLE ignored.
//   - fill_busy = (state==FILL). Remaining count and current address held in registers.
//   - Port ownership per cycle: IDLE/DONE: host owns, host_ready=1.
//     FILL, host_valid=0: fill writes. FILL, host_valid=1: alternate; turn flag toggles after
//     every granted write, host_ready=1 only on host turn. Each side gets >=1 write per 2 cycles.
//   - host_ready is combinational from state, turn flag, fill_abort (abort cycle: host owns).
//   - Latency: granted write appears on write_ce/ad/data on the next clk edge (1 cycle).
//     No grant: write_ce=0 next cycle; write_ad/write_data hold their last values.
//   - Fill address increments by 1 modulo 2**ADDR_W (base 0x7FE, len 4 -> 7FE,7FF,000,001).
//   - fill_len = 2**ADDR_W writes every location exactly once.
//   - Simultaneous host write and fill write to same address in adjacent cycles: issue order
//     is grant order; last issued wins in RAM. No merging.
// STRUCTURE
//   - Shared package vram_pkg: VRAM_ADDR_W=11, VRAM_DATA_W=8, fill state enum
//     {FILL_IDLE, FILL_RUN, FILL_DONE}.
//   - Sub-module vram_fill_counter: address/remaining-count registers, load/step, last flag.
//   - Top: FSM, turn flag, output mux and registers.
// TESTING
//   1. Host only: valid with ad=0x010,data=0x41 -> ready=1 same cycle; next cycle ce=1,ad=0x010,data=0x41.
//   2. Fill base=0x100,len=3,value=0x20, no host -> ce high 3 cycles at 100,101,102; done pulse once; busy=0 after.
//   3. Fill base=0,len=8 with host_valid held high -> alternating grants; host gets 8 writes
//      interleaved, fill finishes after 16 port cycles; ready low exactly on fill turns.
//   4. Wrap: base=0x7FE,len=4 -> addresses 7FE,7FF,000,001; done after 001.
//   5. fill_len=0 -> no write_ce, done pulse next cycle; fill_start while busy -> ignored, count unchanged.
//   6. Abort after 2 of 10 writes and reset during fill -> no further fill writes, no done, busy=0,
//      write_ce=0 the following cycle; host immediately ready.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared video RAM geometry and fill-engine type definitions.
package vram_pkg;

  localparam int unsigned VRAM_ADDR_W = 11;
  localparam int unsigned VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_e;

  typedef enum logic {
    TURN_HOST,
    TURN_FILL
  } turn_e;

endpackage

// File: rtl/vram_fill_counter.sv
// Fill engine address and remaining-count registers; last flags the final write.
module vram_fill_counter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ADDR_W:0]   rem_d,  rem_q;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_base;
      rem_d  = load_len;
    end else if (step) begin
      // Address wraps naturally at 2**ADDR_W.
      addr_d = addr_q + 1'b1;
      rem_d  = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == {{ADDR_W{1'b0}}, 1'b1});

endmodule

// File: rtl/vram_write_arbiter.sv
// Arbitrates the video RAM write port between the host channel and the fill engine.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = VRAM_ADDR_W,
  parameter int unsigned DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_ad,
  input  logic [DATA_W-1:0] host_data,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [ADDR_W:0]   fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              write_ce,
  output logic [ADDR_W-1:0] write_ad,
  output logic [DATA_W-1:0] write_data
);

  fill_state_e       state_d, state_q;
  turn_e             turn_d, turn_q;
  logic [DATA_W-1:0] value_d, value_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic              ce_d, ce_q;
  logic [ADDR_W-1:0] ad_d, ad_q;
  logic [DATA_W-1:0] data_d, data_q;

  logic              start_ok;
  logic              host_grant;
  logic              fill_grant;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_last;

  vram_fill_counter #(
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (start_ok),
    .step      (fill_grant),
    .load_base (fill_base),
    .load_len  (fill_len),
    .addr      (fill_addr),
    .last      (fill_last)
  );

  always_comb begin
    // Host owns the port outside a fill, and also during the abort cycle.
    host_ready = (state_q != FILL_RUN) || fill_abort || (turn_q == TURN_HOST);
    host_grant = host_valid && host_ready;
    fill_grant = (state_q == FILL_RUN) && !fill_abort && !host_grant;
    start_ok   = (state_q == FILL_IDLE) && fill_start && !fill_abort;

    state_d = state_q;
    turn_d  = turn_q;
    value_d = value_q;
    unique case (state_q)
      FILL_IDLE: begin
        if (start_ok) begin
          value_d = fill_value;
          turn_d  = TURN_HOST;
          state_d = (fill_len == '0) ? FILL_DONE : FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (fill_abort) begin
          state_d = FILL_IDLE;
        end else begin
          // A write is always granted here, so the turn flips every cycle.
          turn_d = (turn_q == TURN_HOST) ? TURN_FILL : TURN_HOST;
          if (fill_grant && fill_last) state_d = FILL_DONE;
        end
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase

    busy_d = (state_d == FILL_RUN);
    done_d = (state_d == FILL_DONE);

    ce_d   = host_grant || fill_grant;
    ad_d   = ad_q;
    data_d = data_q;
    if (host_grant) begin
      ad_d   = host_ad;
      data_d = host_data;
    end else if (fill_grant) begin
      ad_d   = fill_addr;
      data_d = value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL_IDLE;
      turn_q  <= TURN_HOST;
      value_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_q    <= 1'b0;
      ad_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      turn_q  <= turn_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ce_q    <= ce_d;
      ad_q    <= ad_d;
      data_q  <= data_d;
    end
  end

  assign fill_busy  = busy_q;
  assign fill_done  = done_q;
  assign write_ce   = ce_q;
  assign write_ad   = ad_q;
  assign write_data = data_q;

endmodule
